fractal_pixel_scheduler: RTL and testbench
==========================================

Name: fractal_pixel_scheduler

Overview:
- Frame-level sequencer for the fractal iteration core inside tt_um_fractal.
- Walks a raster of H_RES x V_RES pixels and derives each pixel's complex coordinate c incrementally, with no multipliers.
- Issues one job at a time to the iteration core and waits for its escape count.
- Forwards the count as a pixel beat to the output/display path using valid/ready backpressure.

Parameters:
- H_RES, 160, pixels per line (>=2)
- V_RES, 120, lines per frame (>=2)
- COORD_W, 16, signed fixed-point coordinate width (Q4.12)
- ITER_W, 8, iteration count width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- cfg_re0  in  COORD_W  real coordinate of pixel (0,0); latched on accepted start
- cfg_im0  in  COORD_W  imaginary coordinate of pixel (0,0); latched on start
- cfg_step  in  COORD_W  coordinate delta per pixel; latched on start
- cfg_max_iter  in  ITER_W  iteration limit; latched on start
- busy  out  1  high from accepted start until frame_done cycle inclusive
- frame_done  out  1  one-cycle pulse after last pixel accepted
- job_valid  out  1  job offered to iteration core
- job_ready  in  1  core accepts job
- job_c_re  out  COORD_W  c real part
- job_c_im  out  COORD_W  c imaginary part
- job_max_iter  out  ITER_W  latched limit
- res_valid  in  1  core result strobe (single cycle)
- res_iter  in  ITER_W  escape count
- pix_valid  out  1  pixel beat valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  clog2(H_RES)  column
- pix_y  out  clog2(V_RES)  row
- pix_iter  out  ITER_W  escape count
- pix_inside  out  1  res_iter == latched max_iter

Behaviour:
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- Reset: state IDLE; busy, frame_done, job_valid and pix_valid all 0; x, y, pix_x, pix_y, pix_iter and pix_inside 0; c registers 0.
- rst wins over every other input, including mid-frame: the in-flight job is abandoned and late results are ignored.
- IDLE: start=1 latches the cfg_* inputs, sets x=y=0, c_re=cfg_re0, c_im=cfg_im0, goes to ISSUE. job_valid rises the cycle after start.
- start outside IDLE is ignored.
- ISSUE: job_valid=1, job_c_* and job_max_iter held stable until job_valid && job_ready, then go to WAIT.
- WAIT: job_valid=0. res_valid=1 captures res_iter into pix_iter, computes pix_inside, and goes to EMIT; pix_valid rises the next cycle.
- res_valid in any state other than WAIT is ignored.
- EMIT: pix_valid=1, pix_* stable until pix_valid && pix_ready. On acceptance:
  - if x < H_RES-1: x+=1, c_re+=cfg_step → ISSUE
  - else if y < V_RES-1: x=0, y+=1, c_re=cfg_re0, c_im-=cfg_step → ISSUE
  - else → DONE
- DONE: frame_done=1 for exactly one cycle, then IDLE. busy drops together with frame_done.
- Coordinate arithmetic: COORD_W-bit two's-complement add/sub, wrapping, no saturation. c_im decreases with y (screen-down).
- Only one job is outstanding at any time. Pixels are emitted strictly in raster order.
- Minimum per-pixel cost with ready always high and a zero-latency core: 3 cycles (ISSUE, WAIT, EMIT).

Optional Feature:
- Macro: FRACTAL_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in ISSUE, WAIT or EMIT forces DONE the next cycle. frame_done still pulses and busy clears.
  - A pending pix beat is dropped: pix_valid deasserts without a handshake.
  - abort in IDLE or DONE has no effect; rst has priority over abort.
- Undefined: no abort port; a frame always runs to completion.

Decomposition:
- Package fractal_pkg:
  - COORD_W and ITER_W localparams
  - coord_t and iter_t typedefs
  - sched_state_t enum {IDLE, ISSUE, WAIT, EMIT, DONE}
- Sub-module fractal_coord_stepper holds the x/y counters and c_re/c_im accumulators, with load, advance, last_col and last_pix signals. The FSM stays in fractal_pixel_scheduler.

Test Plan (bench params H_RES=4, V_RES=3):
- Nominal frame: re0=0xE000, im0=0x1000, step=0x0400, max_iter=16, core returns count = job index, pix_ready=1.
  - Expect 12 pixels in raster order, (x,y)=(0,0)..(3,2).
  - Pixel (3,0): job_c_re=0xEC00. Pixel (0,1): job_c_re=0xE000, job_c_im=0x0C00.
  - Exactly one frame_done pulse; busy low after it.
- Backpressure: hold job_ready=0 for 5 cycles, then pix_ready=0 for 4 cycles.
  - job_* and pix_* remain stable throughout the stalls; no pixel is lost or duplicated.
- Inside flag: core returns 16 for pixel (1,1) → pix_inside=1 on that beat only; 15 elsewhere → 0.
- Spurious inputs:
  - res_valid pulsed during ISSUE and IDLE is ignored; pixel count remains 12.
  - start pulsed mid-frame does not restart the frame or re-latch cfg.
- Reset mid-frame: rst during WAIT of pixel (2,1).
  - Next cycle all outputs are at their reset values.
  - A late res_valid produces no pix beat.
  - A new start produces pixel (0,0) with the new cfg.
- FRACTAL_SCHED_ABORT_EN: abort during EMIT of pixel (1,0) → pix_valid drops, frame_done pulses the next cycle, then IDLE. Without the macro, the bench confirms the port is absent.

Source files
------------

// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared widths, types and state encoding for the fractal pixel scheduler
package fractal_pkg;

    localparam int COORD_W = 16;
    localparam int ITER_W  = 8;

    // Coordinates are Q4.12 two's complement; all arithmetic on them wraps.
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic        [ITER_W-1:0]  iter_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/fractal_coord_stepper.sv
// rtl/fractal_coord_stepper.sv - raster x/y counters and incremental c_re/c_im accumulators
module fractal_coord_stepper
    import fractal_pkg::*;
#(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_advance,
    input  coord_t        i_re0,
    input  coord_t        i_im0,
    input  coord_t        i_step,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output coord_t        o_c_re,
    output coord_t        o_c_im,
    output logic          o_last_col,
    output logic          o_last_pix
);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    coord_t        r_c_re;
    coord_t        r_c_im;
    coord_t        r_re0;
    coord_t        r_step;

    logic w_last_col;
    logic w_last_row;

    assign w_last_col = (r_x == X_LAST);
    assign w_last_row = (r_y == Y_LAST);

    // c is walked by repeated addition so no multiplier is needed; the line
    // start is restored from the latched origin rather than by subtraction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_c_re <= '0;
            r_c_im <= '0;
            r_re0  <= '0;
            r_step <= '0;
        end else if (i_load) begin
            r_x    <= '0;
            r_y    <= '0;
            r_c_re <= i_re0;
            r_c_im <= i_im0;
            r_re0  <= i_re0;
            r_step <= i_step;
        end else if (i_advance) begin
            if (!w_last_col) begin
                r_x    <= r_x + 1'b1;
                r_c_re <= r_c_re + r_step;
            end else begin
                r_x    <= '0;
                r_y    <= r_y + 1'b1;
                r_c_re <= r_re0;
                r_c_im <= r_c_im - r_step;
            end
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_c_re     = r_c_re;
    assign o_c_im     = r_c_im;
    assign o_last_col = w_last_col;
    assign o_last_pix = w_last_col && w_last_row;

endmodule

// File: rtl/fractal_pixel_scheduler.sv
// rtl/fractal_pixel_scheduler.sv - frame sequencer feeding the iteration core; FRACTAL_SCHED_ABORT_EN adds i_abort
module fractal_pixel_scheduler
    import fractal_pkg::*;
#(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  coord_t        i_cfg_re0,
    input  coord_t        i_cfg_im0,
    input  coord_t        i_cfg_step,
    input  iter_t         i_cfg_max_iter,
`ifdef FRACTAL_SCHED_ABORT_EN
    input  logic          i_abort,
`endif
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_job_valid,
    input  logic          i_job_ready,
    output coord_t        o_job_c_re,
    output coord_t        o_job_c_im,
    output iter_t         o_job_max_iter,
    input  logic          i_res_valid,
    input  iter_t         i_res_iter,
    output logic          o_pix_valid,
    input  logic          i_pix_ready,
    output logic [XW-1:0] o_pix_x,
    output logic [YW-1:0] o_pix_y,
    output iter_t         o_pix_iter,
    output logic          o_pix_inside
);

    sched_state_t  r_state;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_job_valid;
    logic          r_pix_valid;
    logic [XW-1:0] r_pix_x;
    logic [YW-1:0] r_pix_y;
    iter_t         r_pix_iter;
    logic          r_pix_inside;
    iter_t         r_max_iter;

    logic          w_load;
    logic          w_advance;
    logic          w_abort;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    coord_t        w_c_re;
    coord_t        w_c_im;
    logic          w_last_col;
    logic          w_last_pix;

`ifdef FRACTAL_SCHED_ABORT_EN
    assign w_abort = i_abort && ((r_state == ISSUE) || (r_state == WAIT) || (r_state == EMIT));
`else
    assign w_abort = 1'b0;
`endif

    assign w_load    = (r_state == IDLE) && i_start;
    assign w_advance = (r_state == EMIT) && i_pix_ready && !w_last_pix && !w_abort;

    fractal_coord_stepper #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_stepper (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_re0      (i_cfg_re0),
        .i_im0      (i_cfg_im0),
        .i_step     (i_cfg_step),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_c_re     (w_c_re),
        .o_c_im     (w_c_im),
        .o_last_col (w_last_col),
        .o_last_pix (w_last_pix)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_job_valid  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_iter   <= '0;
            r_pix_inside <= 1'b0;
            r_max_iter   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_abort) begin
                // Any pending job or pixel beat is dropped without a handshake.
                r_job_valid  <= 1'b0;
                r_pix_valid  <= 1'b0;
                r_frame_done <= 1'b1;
                r_state      <= DONE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_max_iter  <= i_cfg_max_iter;
                            r_busy      <= 1'b1;
                            r_job_valid <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (i_job_ready) begin
                            r_job_valid <= 1'b0;
                            r_state     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (i_res_valid) begin
                            r_pix_x      <= w_x;
                            r_pix_y      <= w_y;
                            r_pix_iter   <= i_res_iter;
                            r_pix_inside <= (i_res_iter == r_max_iter);
                            r_pix_valid  <= 1'b1;
                            r_state      <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (i_pix_ready) begin
                            r_pix_valid <= 1'b0;
                            if (w_last_pix) begin
                                r_frame_done <= 1'b1;
                                r_state      <= DONE;
                            end else begin
                                r_job_valid <= 1'b1;
                                r_state     <= ISSUE;
                            end
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy      <= 1'b0;
                        r_job_valid <= 1'b0;
                        r_pix_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy         = r_busy;
    assign o_frame_done   = r_frame_done;
    assign o_job_valid    = r_job_valid;
    assign o_job_c_re     = w_c_re;
    assign o_job_c_im     = w_c_im;
    assign o_job_max_iter = r_max_iter;
    assign o_pix_valid    = r_pix_valid;
    assign o_pix_x        = r_pix_x;
    assign o_pix_y        = r_pix_y;
    assign o_pix_iter     = r_pix_iter;
    assign o_pix_inside   = r_pix_inside;

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// tb/tb_fractal_pixel_scheduler.sv - randomized self-checking bench for fractal_pixel_scheduler (H_RES=4, V_RES=3)
module tb_fractal_pixel_scheduler;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_re0, cfg_im0, cfg_step;
    logic [7:0]  cfg_max_iter;
    logic        abort;
    logic        busy, frame_done, job_valid, job_ready;
    logic [15:0] job_c_re, job_c_im;
    logic [7:0]  job_max_iter;
    logic        res_valid;
    logic [7:0]  res_iter;
    logic        pix_valid, pix_ready;
    logic [1:0]  pix_x, pix_y;
    logic [7:0]  pix_iter;
    logic        pix_inside;

    int n_cmp = 0;
    int n_err = 0;

    fractal_pixel_scheduler #(.H_RES(H), .V_RES(V)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_cfg_re0      (cfg_re0),
        .i_cfg_im0      (cfg_im0),
        .i_cfg_step     (cfg_step),
        .i_cfg_max_iter (cfg_max_iter),
`ifdef FRACTAL_SCHED_ABORT_EN
        .i_abort        (abort),
`endif
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_job_valid    (job_valid),
        .i_job_ready    (job_ready),
        .o_job_c_re     (job_c_re),
        .o_job_c_im     (job_c_im),
        .o_job_max_iter (job_max_iter),
        .i_res_valid    (res_valid),
        .i_res_iter     (res_iter),
        .o_pix_valid    (pix_valid),
        .i_pix_ready    (pix_ready),
        .o_pix_x        (pix_x),
        .o_pix_y        (pix_y),
        .o_pix_iter     (pix_iter),
        .o_pix_inside   (pix_inside)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pixel k sits at (k%H, k/H); c = origin + x*step - i*y*step.
    // Core iteration count per mode: 0 = job index, 1 = 16 at (1,1) else 15, 2 = random 0..3.
    task automatic run_frame(input logic [15:0] re0, input logic [15:0] im0, input logic [15:0] step,
                             input logic [7:0] mi, input int mode, input int jstall, input int pstall,
                             input int maxlat, input int jhold, input int phold, input bit spur,
                             input int stop_at, input int abort_at, input bit fast);
        int pix_n = 0, phase = 0, lat = 0, cyc = 0, jheld = 0, pheld = 0, exp_n, x, y;
        logic [15:0] e_re, e_im;
        logic [7:0]  cur_it = 8'd0;
        @(negedge clk);
        cfg_re0 = re0; cfg_im0 = im0; cfg_step = step; cfg_max_iter = mi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_re0 = 16'($urandom); cfg_im0 = 16'($urandom); cfg_step = 16'($urandom); cfg_max_iter = 8'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b want 1", busy); end
        while (phase != 9) begin
            cyc++;
            start = 1'b0; job_ready = 1'b0; res_valid = 1'b0; pix_ready = 1'b0;
            x = pix_n % H; y = pix_n / H;
            e_re = re0 + step * 16'(x);
            e_im = im0 - step * 16'(y);
            if (cyc > 3000) begin
                n_err++; n_cmp++;
                $display("FAIL timeout: phase %0d pixel %0d got no progress", phase, pix_n);
                phase = 9;
            end else begin
                case (phase)
                    0: begin
                        n_cmp++;
                        if (job_valid !== 1'b1 || pix_valid !== 1'b0) begin
                            n_err++;
                            $display("FAIL issue_flags: got job_valid=%b pix_valid=%b want 1/0", job_valid, pix_valid);
                        end
                        n_cmp++;
                        if ({job_c_re, job_c_im, job_max_iter} !== {e_re, e_im, mi}) begin
                            n_err++;
                            $display("FAIL job_fields px%0d: got %h/%h/%h want %h/%h/%h",
                                     pix_n, job_c_re, job_c_im, job_max_iter, e_re, e_im, mi);
                        end
                        if (job_valid === 1'b1) begin
                            job_ready = ($urandom_range(99) >= 32'(jstall));
                            if (pix_n == 1 && jheld < jhold) begin job_ready = 1'b0; jheld++; end
                            if (job_ready) begin phase = 1; lat = $urandom_range(maxlat); end
                        end
                        if (spur && $urandom_range(3) == 0) begin res_valid = 1'b1; res_iter = 8'($urandom); end
                        if (spur && $urandom_range(5) == 0) begin start = 1'b1; cfg_re0 = 16'($urandom); end
                    end
                    1: begin
                        n_cmp++;
                        if (job_valid !== 1'b0 || pix_valid !== 1'b0) begin
                            n_err++;
                            $display("FAIL wait_flags: got job_valid=%b pix_valid=%b want 0/0", job_valid, pix_valid);
                        end
                        if (pix_n == stop_at) phase = 9;
                        else if (lat == 0) begin
                            cur_it = (mode == 0) ? 8'(pix_n) :
                                     (mode == 1) ? ((x == 1 && y == 1) ? 8'd16 : 8'd15) : 8'($urandom_range(3));
                            res_valid = 1'b1; res_iter = cur_it; phase = 2;
                        end else lat--;
                    end
                    2: begin
                        n_cmp++;
                        if ({pix_valid, pix_x, pix_y, pix_iter, pix_inside, job_valid} !==
                            {1'b1, 2'(x), 2'(y), cur_it, (cur_it == mi), 1'b0}) begin
                            n_err++;
                            $display("FAIL pix_beat px%0d: got v%b x%0d y%0d it%0d in%b jv%b want v1 x%0d y%0d it%0d in%b jv0",
                                     pix_n, pix_valid, pix_x, pix_y, pix_iter, pix_inside, job_valid,
                                     x, y, cur_it, (cur_it == mi));
                        end
                        if (pix_n == abort_at) begin
`ifdef FRACTAL_SCHED_ABORT_EN
                            abort = 1'b1;
`endif
                            phase = 4;
                        end else begin
                            pix_ready = ($urandom_range(99) >= 32'(pstall));
                            if (pix_n == 1 && pheld < phold) begin pix_ready = 1'b0; pheld++; end
                            if (pix_ready) begin pix_n++; phase = (pix_n == H * V) ? 3 : 0; end
                        end
                    end
                    3, 4: begin
                        abort = 1'b0;
                        n_cmp++;
                        if ({frame_done, busy, pix_valid, job_valid} !== 4'b1100) begin
                            n_err++;
                            $display("FAIL done_pulse: got fd%b busy%b pv%b jv%b want 1 1 0 0",
                                     frame_done, busy, pix_valid, job_valid);
                        end
                        if (fast) begin
                            n_cmp++;
                            if (cyc != H * V * 3 + 1) begin
                                n_err++; $display("FAIL frame_cycles: got %0d want %0d", cyc, H * V * 3 + 1);
                            end
                        end
                        phase = 5;
                    end
                    5, 6: begin
                        n_cmp++;
                        if ({frame_done, busy, pix_valid, job_valid} !== 4'b0000) begin
                            n_err++;
                            $display("FAIL after_done: got fd%b busy%b pv%b jv%b want 0 0 0 0",
                                     frame_done, busy, pix_valid, job_valid);
                        end
                        phase = (phase == 5) ? 6 : 9;
                    end
                    default: phase = 9;
                endcase
            end
            if (phase != 9) @(negedge clk);
        end
        exp_n = (stop_at >= 0) ? stop_at : (abort_at >= 0) ? abort_at : H * V;
        n_cmp++;
        if (pix_n != exp_n) begin n_err++; $display("FAIL pixel_count: got %0d want %0d", pix_n, exp_n); end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({busy, frame_done, job_valid, pix_valid, pix_x, pix_y, pix_iter, pix_inside, job_c_re, job_c_im} !== '0) begin
            n_err++;
            $display("FAIL %s: got busy%b fd%b jv%b pv%b x%0d y%0d it%h in%b re%h im%h want all 0", tag,
                     busy, frame_done, job_valid, pix_valid, pix_x, pix_y, pix_iter, pix_inside, job_c_re, job_c_im);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_nominal;
        run_frame(16'hE000, 16'h1000, 16'h0400, 8'd16, 0, 0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b1);
    endtask

    task automatic test_backpressure;
        run_frame(16'hE000, 16'h1000, 16'h0400, 8'd16, 0, 30, 30, 2, 5, 4, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_inside;
        run_frame(16'h8000, 16'h7F00, 16'h0123, 8'd16, 1, 20, 20, 1, 0, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_spurious;
        @(negedge clk);
        res_valid = 1'b1; res_iter = 8'h3C;
        @(negedge clk);
        res_valid = 1'b0;
        n_cmp++;
        if ({busy, pix_valid, job_valid} !== 3'b000) begin
            n_err++; $display("FAIL idle_res_ignored: got busy%b pv%b jv%b want 0 0 0", busy, pix_valid, job_valid);
        end
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 8'd2, 2, 25, 25, 2, 0, 0, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_frame(16'h1234, 16'hF000, 16'h0100, 8'd16, 0, 20, 20, 0, 0, 0, 1'b0, 6, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset_mid_frame");
        res_valid = 1'b1; res_iter = 8'h55;
        @(negedge clk);
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({pix_valid, busy, job_valid} !== 3'b000) begin
                n_err++; $display("FAIL late_result: got pv%b busy%b jv%b want 0 0 0", pix_valid, busy, job_valid);
            end
            @(negedge clk);
        end
        run_frame(16'hC000, 16'h0800, 16'h0200, 8'd5, 2, 10, 10, 1, 0, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 2; f++)
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b1);
    endtask

`ifdef FRACTAL_SCHED_ABORT_EN
    task automatic test_abort;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({busy, frame_done} !== 2'b00) begin
            n_err++; $display("FAIL idle_abort_ignored: got busy%b fd%b want 0 0", busy, frame_done);
        end
        run_frame(16'hE000, 16'h1000, 16'h0400, 8'd16, 0, 0, 0, 0, 0, 0, 1'b0, -1, 1, 1'b0);
        run_frame(16'hE000, 16'h1000, 16'h0400, 8'd16, 0, 0, 0, 0, 0, 0, 1'b0, -1, -1, 1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_re0 = '0; cfg_im0 = '0; cfg_step = '0; cfg_max_iter = '0;
        job_ready = 1'b0; res_valid = 1'b0; res_iter = '0; pix_ready = 1'b0;
        test_reset;
        test_nominal;
        test_backpressure;
        test_inside;
        test_spurious;
        test_reset_mid;
        test_back_to_back;
`ifdef FRACTAL_SCHED_ABORT_EN
        test_abort;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
